pie_encoder: RTL

PIE_ENCODER -- requirements
Module: pie_encoder

---
 rtl/pie_pkg.sv | 26 ++
 rtl/pie_symbol_timer.sv | 27 ++
 rtl/pie_encoder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pie_pkg.sv
// Shared state encoding and default PIE timing for the reader-side encoder.
// Timing values are in clk cycles.
package pie_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELIM,
        D0CAL,
        RTCAL,
        TRCAL,
        DATA
    } pie_state_t;

    typedef enum logic {
        PH_HIGH,
        PH_LOW
    } pie_phase_t;

    localparam int DEF_DELIM_CYC = 24;
    localparam int DEF_PW_CYC    = 12;
    localparam int DEF_DATA0_CYC = 24;
    localparam int DEF_DATA1_CYC = 40;
    localparam int DEF_TRCAL_CYC = 96;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/pie_symbol_timer.sv
// Phase down-counter: loads length-1 on load, counts down, and flags
// expired while it sits at zero.
module pie_symbol_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] length,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= length - CNT_W'(1);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/pie_encoder.sv
// PIE frame encoder: delimiter, calibration symbols and data bits shaped as
// high-then-low pulses on a registered modulation output.
module pie_encoder
    import pie_pkg::*;
#(
    parameter int DELIM_CYC = DEF_DELIM_CYC,
    parameter int PW_CYC    = DEF_PW_CYC,
    parameter int DATA0_CYC = DEF_DATA0_CYC,
    parameter int DATA1_CYC = DEF_DATA1_CYC,
    parameter int TRCAL_CYC = DEF_TRCAL_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic preamble_sel,
    input  logic abort,
    input  logic data_bit,
    input  logic data_last,
    input  logic data_valid,
    output logic data_ready,
    output logic mod_out,
    output logic busy,
    output logic done,
    output logic underrun
);

    localparam int RTCAL_CYC = DATA0_CYC + DATA1_CYC;

    if (DELIM_CYC >= 2**CNT_W || DATA1_CYC >= 2**CNT_W || RTCAL_CYC >= 2**CNT_W ||
        TRCAL_CYC >= 2**CNT_W || DATA0_CYC >= 2**CNT_W) begin : g_bad_width
        $error("pie_encoder: a phase length does not fit in CNT_W bits");
    end
    if (PW_CYC < 1 || DELIM_CYC < 1 || PW_CYC >= DATA0_CYC || DATA1_CYC <= DATA0_CYC) begin : g_bad_pw
        $error("pie_encoder: PW_CYC must be at least 1 and shorter than DATA0_CYC");
    end
    if (10 * TRCAL_CYC < 11 * RTCAL_CYC || TRCAL_CYC > 3 * RTCAL_CYC) begin : g_bad_trcal
        $error("pie_encoder: TRCAL_CYC must lie between 1.1x and 3x RTcal");
    end

    localparam logic [CNT_W-1:0] LEN_DELIM = CNT_W'(DELIM_CYC);
    localparam logic [CNT_W-1:0] LEN_PW    = CNT_W'(PW_CYC);
    localparam logic [CNT_W-1:0] LEN_D0_HI = CNT_W'(DATA0_CYC - PW_CYC);
    localparam logic [CNT_W-1:0] LEN_D1_HI = CNT_W'(DATA1_CYC - PW_CYC);
    localparam logic [CNT_W-1:0] LEN_RT_HI = CNT_W'(RTCAL_CYC - PW_CYC);
    localparam logic [CNT_W-1:0] LEN_TR_HI = CNT_W'(TRCAL_CYC - PW_CYC);

    pie_state_t       state_q, state_n;
    pie_phase_t       phase_q, phase_n;
    logic             sel_q, sel_n;
    logic             last_q, last_n;
    logic             underrun_n;
    logic             done_n;
    logic             mod_n;
    logic             want_bit;
    logic             timer_load;
    logic [CNT_W-1:0] timer_len;
    logic             timer_expired;

    pie_symbol_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .length  (timer_len),
        .expired (timer_expired)
    );

    always_comb begin
        state_n    = state_q;
        phase_n    = phase_q;
        sel_n      = sel_q;
        last_n     = last_q;
        underrun_n = underrun;
        done_n     = 1'b0;
        timer_load = 1'b0;
        timer_len  = '0;
        data_ready = 1'b0;
        want_bit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n    = DELIM;
                    phase_n    = PH_LOW;
                    sel_n      = preamble_sel;
                    underrun_n = 1'b0;
                    timer_load = 1'b1;
                    timer_len  = LEN_DELIM;
                end
            end
            DELIM: begin
                if (timer_expired) begin
                    state_n    = D0CAL;
                    phase_n    = PH_HIGH;
                    timer_load = 1'b1;
                    timer_len  = LEN_D0_HI;
                end
            end
            default: begin
                if (timer_expired) begin
                    if (phase_q == PH_HIGH) begin
                        phase_n    = PH_LOW;
                        timer_load = 1'b1;
                        timer_len  = LEN_PW;
                    end else begin
                        case (state_q)
                            D0CAL: begin
                                state_n    = RTCAL;
                                phase_n    = PH_HIGH;
                                timer_load = 1'b1;
                                timer_len  = LEN_RT_HI;
                            end
                            RTCAL: begin
                                if (sel_q) begin
                                    state_n    = TRCAL;
                                    phase_n    = PH_HIGH;
                                    timer_load = 1'b1;
                                    timer_len  = LEN_TR_HI;
                                end else begin
                                    want_bit = 1'b1;
                                end
                            end
                            TRCAL: want_bit = 1'b1;
                            default: begin
                                if (last_q) begin
                                    state_n = IDLE;
                                    phase_n = PH_HIGH;
                                    done_n  = 1'b1;
                                end else begin
                                    want_bit = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
        endcase

        // The bit handshake sits on the last low cycle so the next symbol starts with no gap;
        // a missing bit ends the frame cleanly instead of emitting a partial symbol.
        if (want_bit) begin
            data_ready = 1'b1;
            if (data_valid) begin
                state_n    = DATA;
                phase_n    = PH_HIGH;
                last_n     = data_last;
                timer_load = 1'b1;
                timer_len  = data_bit ? LEN_D1_HI : LEN_D0_HI;
            end else begin
                state_n    = IDLE;
                phase_n    = PH_HIGH;
                underrun_n = 1'b1;
                done_n     = 1'b1;
            end
        end

        if (abort && state_q != IDLE) begin
            state_n    = IDLE;
            phase_n    = PH_HIGH;
            data_ready = 1'b0;
            underrun_n = underrun;
            done_n     = 1'b0;
            timer_load = 1'b0;
        end

        case (state_n)
            IDLE:    mod_n = 1'b1;
            DELIM:   mod_n = 1'b0;
            default: mod_n = (phase_n == PH_HIGH);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= PH_HIGH;
            sel_q    <= 1'b0;
            last_q   <= 1'b0;
            mod_out  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state_q  <= state_n;
            phase_q  <= phase_n;
            sel_q    <= sel_n;
            last_q   <= last_n;
            mod_out  <= mod_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
            underrun <= underrun_n;
        end
    end

endmodule
